// File: rtl/spi_xfer_arbiter_pkg.sv
// Shared types and constants for the SPI transfer arbiter: FSM states,
// the "no slave" select code and the data returned on an aborted transfer.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        DONE
    } state_t;

    localparam logic [1:0] SLAVE_NONE   = 2'b11;
    localparam logic [7:0] RSP_ERR_DATA = 8'h00;

    // Round-robin successor of an index in a ring of n entries.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/spi_xfer_arbiter_if.sv
// Requester-side handshake plus SPI engine control bundled as one interface;
// the arbiter uses the slave view, requesters/engine the master view.
interface spi_xfer_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]   req;
    logic [2*NUM_REQ-1:0] req_slave;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [7:0]           rsp_data;
    logic                 rsp_err;
    logic                 busy;
    logic                 spi_start;
    logic [1:0]           spi_slave_select;
    logic [7:0]           spi_tx_data;
    logic [7:0]           spi_rx_data;

    modport slave (
        input  req, req_slave, req_data, spi_rx_data,
        output gnt, rsp_valid, rsp_data, rsp_err, busy,
               spi_start, spi_slave_select, spi_tx_data
    );

    modport master (
        output req, req_slave, req_data, spi_rx_data,
        input  gnt, rsp_valid, rsp_data, rsp_err, busy,
               spi_start, spi_slave_select, spi_tx_data
    );
endinterface

// File: rtl/spi_xfer_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first active request found when
// scanning upward from ptr (wrapping) wins.
module rr_arbiter #(
    parameter  int NUM_REQ = 3,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IDX_W-1:0]   win_idx
);

    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_req;

    // Candidate gi is the requester gi places after the pointer.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [IDX_W:0] sum;
        assign sum          = {1'b0, ptr} + (IDX_W+1)'(gi);
        assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ))
                              ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                              : sum[IDX_W-1:0];
        assign cand_req[gi] = req[cand_idx[gi]];
    end

    always_comb begin
        win_idx = '0;
        win_oh  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                win_idx = cand_idx[k];
            end
        end
        if (|cand_req) begin
            win_oh[win_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Round-robin scheduler sharing one SPI master engine between NUM_REQ
// requesters; the byte exchange is timed by a counter since the engine has no done flag.
module spi_xfer_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int XFER_CYCLES = 10
) (
    input  logic               clk,
    input  logic               reset,
    spi_xfer_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(XFER_CYCLES + 1);

    state_t             state_reg,     state_next;
    logic [IDX_W-1:0]   ptr_reg,       ptr_next;
    logic [IDX_W-1:0]   win_reg,       win_next;
    logic               err_reg,       err_next;
    logic [CNT_W-1:0]   cnt_reg,       cnt_next;
    logic [NUM_REQ-1:0] gnt_reg,       gnt_next;
    logic [NUM_REQ-1:0] rsp_valid_reg, rsp_valid_next;
    logic [7:0]         rsp_data_reg,  rsp_data_next;
    logic               rsp_err_reg,   rsp_err_next;
    logic               busy_reg,      busy_next;
    logic               start_reg,     start_next;
    logic [1:0]         sel_reg,       sel_next;
    logic [7:0]         tx_reg,        tx_next;

    logic [NUM_REQ-1:0] win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_reg_oh;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (bus.req),
        .ptr     (ptr_reg),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    assign win_reg_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // All outputs are registered, so each is computed one cycle ahead here.
    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        win_next       = win_reg;
        err_next       = err_reg;
        cnt_next       = cnt_reg;
        gnt_next       = '0;
        rsp_valid_next = '0;
        rsp_data_next  = RSP_ERR_DATA;
        rsp_err_next   = 1'b0;
        start_next     = 1'b0;
        sel_next       = sel_reg;
        tx_next        = tx_reg;

        case (state_reg)
            IDLE: begin
                if (|bus.req) begin
                    win_next   = win_idx;
                    ptr_next   = IDX_W'(wrap_inc(int'(win_idx), NUM_REQ));
                    gnt_next   = win_oh;
                    sel_next   = bus.req_slave[2*win_idx +: 2];
                    tx_next    = bus.req_data[8*win_idx +: 8];
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (sel_reg == SLAVE_NONE) begin
                    err_next       = 1'b1;
                    rsp_valid_next = win_reg_oh;
                    rsp_err_next   = 1'b1;
                    rsp_data_next  = RSP_ERR_DATA;
                    state_next     = DONE;
                end else begin
                    start_next = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                cnt_next   = CNT_W'(XFER_CYCLES - 1);
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    rsp_valid_next = win_reg_oh;
                    rsp_data_next  = bus.spi_rx_data;
                    rsp_err_next   = err_reg;
                    state_next     = DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DONE: begin
                err_next   = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg       <= '0;
            win_reg       <= '0;
            err_reg       <= 1'b0;
            cnt_reg       <= '0;
            gnt_reg       <= '0;
            rsp_valid_reg <= '0;
            rsp_data_reg  <= RSP_ERR_DATA;
            rsp_err_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            start_reg     <= 1'b0;
            sel_reg       <= SLAVE_NONE;
            tx_reg        <= 8'h00;
        end else begin
            ptr_reg       <= ptr_next;
            win_reg       <= win_next;
            err_reg       <= err_next;
            cnt_reg       <= cnt_next;
            gnt_reg       <= gnt_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_err_reg   <= rsp_err_next;
            busy_reg      <= busy_next;
            start_reg     <= start_next;
            sel_reg       <= sel_next;
            tx_reg        <= tx_next;
        end
    end

    assign bus.gnt              = gnt_reg;
    assign bus.rsp_valid        = rsp_valid_reg;
    assign bus.rsp_data         = rsp_data_reg;
    assign bus.rsp_err          = rsp_err_reg;
    assign bus.busy             = busy_reg;
    assign bus.spi_start        = start_reg;
    assign bus.spi_slave_select = sel_reg;
    assign bus.spi_tx_data      = tx_reg;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed-vector bench for spi_xfer_arbiter: one DUT with XFER_CYCLES=10
// and one with XFER_CYCLES=1, sharing clock and reset.
module tb_spi_xfer_arbiter;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    spi_xfer_arbiter_if #(.NUM_REQ(3)) bus0 ();
    spi_xfer_arbiter_if #(.NUM_REQ(3)) bus1 ();

    spi_xfer_arbiter #(.NUM_REQ(3), .XFER_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    spi_xfer_arbiter #(.NUM_REQ(3), .XFER_CYCLES(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] oh(input int i);
        logic [2:0] v;
        v = 3'b001 << i;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus0.req = 3'b000;
        bus1.req = 3'b000;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_vec++;
        if (bus0.gnt !== 3'b000 || bus0.rsp_valid !== 3'b000 || bus0.spi_start !== 1'b0 ||
            bus0.busy !== 1'b0 || bus0.rsp_err !== 1'b0 || bus0.rsp_data !== 8'h00 ||
            bus0.spi_slave_select !== 2'b11 || bus0.spi_tx_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_state: gnt=%b rv=%b st=%b busy=%b err=%b rd=%h sel=%b tx=%h, required 000 000 0 0 0 00 11 00",
                     bus0.gnt, bus0.rsp_valid, bus0.spi_start, bus0.busy, bus0.rsp_err,
                     bus0.rsp_data, bus0.spi_slave_select, bus0.spi_tx_data);
        end
        n_vec++;
        if (bus1.gnt !== 3'b000 || bus1.busy !== 1'b0 || bus1.spi_slave_select !== 2'b11) begin
            n_err++;
            $display("FAIL reset_state_x1: gnt=%b busy=%b sel=%b, required 000 0 11",
                     bus1.gnt, bus1.busy, bus1.spi_slave_select);
        end
        reset = 1'b0;
        $display("xfer: reset checked");
    endtask

    task automatic test_single();
        logic [2:0] exp_gnt, exp_rv;
        do_reset();
        bus0.req_slave   = 6'b11_11_00;
        bus0.req_data    = {8'h00, 8'h00, 8'hA5};
        bus0.spi_rx_data = 8'h3C;
        bus0.req         = 3'b001;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 1) bus0.req = 3'b000;
            exp_gnt = (c == 1)  ? 3'b001 : 3'b000;
            exp_rv  = (c == 13) ? 3'b001 : 3'b000;
            n_vec++;
            if (bus0.gnt !== exp_gnt) begin
                n_err++;
                $display("FAIL single_gnt c%0d: got %b required %b", c, bus0.gnt, exp_gnt);
            end
            n_vec++;
            if (bus0.spi_start !== (c == 2)) begin
                n_err++;
                $display("FAIL single_start c%0d: got %b required %b", c, bus0.spi_start, (c == 2));
            end
            n_vec++;
            if (bus0.rsp_valid !== exp_rv) begin
                n_err++;
                $display("FAIL single_rsp_valid c%0d: got %b required %b", c, bus0.rsp_valid, exp_rv);
            end
            n_vec++;
            if (bus0.busy !== (c <= 13)) begin
                n_err++;
                $display("FAIL single_busy c%0d: got %b required %b", c, bus0.busy, (c <= 13));
            end
            if (c == 2) begin
                n_vec++;
                if (bus0.spi_slave_select !== 2'b00 || bus0.spi_tx_data !== 8'hA5) begin
                    n_err++;
                    $display("FAIL single_sel_tx: got %b/%h required 00/a5",
                             bus0.spi_slave_select, bus0.spi_tx_data);
                end
            end
            if (c == 13) begin
                n_vec++;
                if (bus0.rsp_data !== 8'h3C || bus0.rsp_err !== 1'b0) begin
                    n_err++;
                    $display("FAIL single_rsp_data: got %h err %b required 3c err 0",
                             bus0.rsp_data, bus0.rsp_err);
                end
            end
        end
        $display("xfer: single requester 0 tx a5 rx 3c");
    endtask

    task automatic test_round_robin();
        int         order [4];
        logic [1:0] slv [3];
        logic [2:0] exp_gnt, exp_rv;
        order = '{0, 1, 2, 0};
        slv   = '{2'b00, 2'b01, 2'b10};
        do_reset();
        bus0.req_slave = {slv[2], slv[1], slv[0]};
        bus0.req_data  = {8'h30, 8'h20, 8'h10};
        bus0.req       = 3'b111;
        for (int c = 1; c <= 56; c++) begin
            tick();
            exp_gnt = ((c % 14) == 1)               ? oh(order[c / 14]) : 3'b000;
            exp_rv  = ((c % 14) == 13 && c < 56)    ? oh(order[c / 14]) : 3'b000;
            n_vec++;
            if (bus0.gnt !== exp_gnt) begin
                n_err++;
                $display("FAIL rr_gnt c%0d: got %b required %b", c, bus0.gnt, exp_gnt);
            end
            n_vec++;
            if (bus0.rsp_valid !== exp_rv) begin
                n_err++;
                $display("FAIL rr_rsp_valid c%0d: got %b required %b", c, bus0.rsp_valid, exp_rv);
            end
            if ((c % 14) == 2) begin
                n_vec++;
                if (bus0.spi_start !== 1'b1 || bus0.spi_slave_select !== slv[order[c / 14]]) begin
                    n_err++;
                    $display("FAIL rr_sel c%0d: start %b sel %b required 1 %b",
                             c, bus0.spi_start, bus0.spi_slave_select, slv[order[c / 14]]);
                end
            end
            if (c == 43) bus0.req = 3'b000;
        end
        tick();
        n_vec++;
        if (bus0.busy !== 1'b0 || bus0.gnt !== 3'b000) begin
            n_err++;
            $display("FAIL rr_end: busy %b gnt %b required 0 000", bus0.busy, bus0.gnt);
        end
        $display("xfer: round robin 0,1,2,0");
    endtask

    task automatic test_invalid_slave();
        logic [2:0] exp_gnt, exp_rv;
        do_reset();
        bus0.req_slave   = 6'b00_11_00;
        bus0.req_data    = {8'h00, 8'h77, 8'h00};
        bus0.spi_rx_data = 8'h5A;
        bus0.req         = 3'b010;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) bus0.req = 3'b000;
            exp_gnt = (c == 1) ? 3'b010 : 3'b000;
            exp_rv  = (c == 2) ? 3'b010 : 3'b000;
            n_vec++;
            if (bus0.gnt !== exp_gnt || bus0.rsp_valid !== exp_rv || bus0.spi_start !== 1'b0) begin
                n_err++;
                $display("FAIL inv_seq c%0d: gnt %b rv %b start %b required %b %b 0",
                         c, bus0.gnt, bus0.rsp_valid, bus0.spi_start, exp_gnt, exp_rv);
            end
            if (c == 2) begin
                n_vec++;
                if (bus0.rsp_err !== 1'b1 || bus0.rsp_data !== 8'h00) begin
                    n_err++;
                    $display("FAIL inv_rsp: err %b data %h required 1 00", bus0.rsp_err, bus0.rsp_data);
                end
            end
            n_vec++;
            if (bus0.busy !== (c <= 2)) begin
                n_err++;
                $display("FAIL inv_busy c%0d: got %b required %b", c, bus0.busy, (c <= 2));
            end
        end
        $display("xfer: invalid slave on requester 1");
    endtask

    task automatic test_reset_mid();
        logic [2:0] exp_gnt, exp_rv;
        do_reset();
        bus0.req_slave   = 6'b00_10_01;
        bus0.req_data    = {8'h00, 8'h44, 8'h77};
        bus0.spi_rx_data = 8'h99;
        bus0.req         = 3'b001;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) bus0.req = 3'b000;
        end
        reset = 1'b1;
        tick();
        n_vec++;
        if (bus0.gnt !== 3'b000 || bus0.rsp_valid !== 3'b000 || bus0.spi_start !== 1'b0 ||
            bus0.busy !== 1'b0 || bus0.rsp_err !== 1'b0 || bus0.rsp_data !== 8'h00 ||
            bus0.spi_slave_select !== 2'b11 || bus0.spi_tx_data !== 8'h00) begin
            n_err++;
            $display("FAIL midreset_state: gnt=%b rv=%b st=%b busy=%b sel=%b tx=%h, required 000 000 0 0 11 00",
                     bus0.gnt, bus0.rsp_valid, bus0.spi_start, bus0.busy,
                     bus0.spi_slave_select, bus0.spi_tx_data);
        end
        reset    = 1'b0;
        bus0.req = 3'b010;
        for (int r = 1; r <= 14; r++) begin
            tick();
            if (r == 1) bus0.req = 3'b000;
            exp_gnt = (r == 1)  ? 3'b010 : 3'b000;
            exp_rv  = (r == 13) ? 3'b010 : 3'b000;
            n_vec++;
            if (bus0.gnt !== exp_gnt || bus0.rsp_valid !== exp_rv) begin
                n_err++;
                $display("FAIL midreset_next r%0d: gnt %b rv %b required %b %b",
                         r, bus0.gnt, bus0.rsp_valid, exp_gnt, exp_rv);
            end
            if (r == 2) begin
                n_vec++;
                if (bus0.spi_slave_select !== 2'b10 || bus0.spi_tx_data !== 8'h44) begin
                    n_err++;
                    $display("FAIL midreset_sel: got %b/%h required 10/44",
                             bus0.spi_slave_select, bus0.spi_tx_data);
                end
            end
        end
        $display("xfer: reset mid-transfer then requester 1");
    endtask

    task automatic test_req_changes();
        logic [2:0] exp_gnt;
        do_reset();
        bus0.req_slave = 6'b10_00_00;
        bus0.req_data  = {8'h11, 8'h00, 8'h00};
        bus0.req       = 3'b100;
        tick();
        n_vec++;
        if (bus0.gnt !== 3'b100) begin
            n_err++;
            $display("FAIL change_gnt: got %b required 100", bus0.gnt);
        end
        bus0.req_data = {8'h22, 8'h00, 8'h00};
        bus0.req      = 3'b000;
        tick();
        n_vec++;
        if (bus0.spi_tx_data !== 8'h11 || bus0.spi_slave_select !== 2'b10) begin
            n_err++;
            $display("FAIL change_tx: got %h/%b required 11/10", bus0.spi_tx_data, bus0.spi_slave_select);
        end
        for (int c = 3; c <= 14; c++) tick();

        bus0.req = 3'b010;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 1) bus0.req = 3'b000;
            if (c == 3) bus0.req = 3'b001;
            if (c == 5) bus0.req = 3'b000;
            exp_gnt = (c == 1) ? 3'b010 : 3'b000;
            n_vec++;
            if (bus0.gnt !== exp_gnt) begin
                n_err++;
                $display("FAIL dropped_req c%0d: gnt %b required %b", c, bus0.gnt, exp_gnt);
            end
        end
        $display("xfer: request data change and dropped request");
    endtask

    task automatic test_xfer1();
        logic [2:0] exp_gnt, exp_rv;
        do_reset();
        bus1.req_slave   = 6'b11_11_01;
        bus1.req_data    = {8'h00, 8'h00, 8'hC3};
        bus1.spi_rx_data = 8'h96;
        bus1.req         = 3'b001;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) bus1.req = 3'b000;
            exp_gnt = (c == 1) ? 3'b001 : 3'b000;
            exp_rv  = (c == 4) ? 3'b001 : 3'b000;
            n_vec++;
            if (bus1.gnt !== exp_gnt || bus1.rsp_valid !== exp_rv || bus1.spi_start !== (c == 2)) begin
                n_err++;
                $display("FAIL x1_seq c%0d: gnt %b rv %b start %b required %b %b %b",
                         c, bus1.gnt, bus1.rsp_valid, bus1.spi_start, exp_gnt, exp_rv, (c == 2));
            end
            if (c == 2) begin
                n_vec++;
                if (bus1.spi_slave_select !== 2'b01 || bus1.spi_tx_data !== 8'hC3) begin
                    n_err++;
                    $display("FAIL x1_sel_tx: got %b/%h required 01/c3",
                             bus1.spi_slave_select, bus1.spi_tx_data);
                end
            end
            if (c == 4) begin
                n_vec++;
                if (bus1.rsp_data !== 8'h96 || bus1.rsp_err !== 1'b0) begin
                    n_err++;
                    $display("FAIL x1_rsp: data %h err %b required 96 0", bus1.rsp_data, bus1.rsp_err);
                end
            end
            n_vec++;
            if (bus1.busy !== (c <= 4)) begin
                n_err++;
                $display("FAIL x1_busy c%0d: got %b required %b", c, bus1.busy, (c <= 4));
            end
        end
        $display("xfer: XFER_CYCLES=1 requester 0 rx 96");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus0.req = 3'b000; bus0.req_slave = '1; bus0.req_data = '0; bus0.spi_rx_data = 8'h00;
        bus1.req = 3'b000; bus1.req_slave = '1; bus1.req_data = '0; bus1.spi_rx_data = 8'h00;
        test_reset();
        test_single();
        test_round_robin();
        test_invalid_slave();
        test_reset_mid();
        test_req_changes();
        test_xfer1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
